// File: rtl/pc_fetch_controller.sv
// Purpose     : fetch-PC sequencer; drives the next-PC mux candidates and a one-outstanding imem port.
// Latency     : 3 cycles per fetch with zero-wait memory (REQ grant, rvalid, decode accept).
// Backpressure: stall_i holds the presented instruction; a redirect kills it and refetches.
//
// Ports:
//   clk, reset                         clock, async active-high reset
//   branch_taken_i / branch_target_i   single-cycle redirect request from execute
//   stall_i                            decode cannot accept the presented instruction
//   pc_select_o / pc_add_o / pc_branch_o / pc_next_i   external next-PC mux interface
//   imem_req_o / imem_addr_o / imem_gnt_i / imem_rvalid_i / imem_rdata_i   fetch port
//   instr_valid_o / instr_o / instr_pc_o                                   decode interface
//
// Optional macro PC_MISALIGN_HALT_EN: adds misalign_o and a terminal HALT state entered when a
// misaligned PC is loaded. Without it, pc_next_i[1:0] is forced to zero on every load.

module pc_fetch_controller #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] PC_STEP      = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        stall_i,
    output logic        pc_select_o,
    output logic [31:0] pc_add_o,
    output logic [31:0] pc_branch_o,
    input  logic [31:0] pc_next_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o
`ifdef PC_MISALIGN_HALT_EN
    ,
    output logic        misalign_o
`endif
);

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_REQ,
        ST_WAIT_RSP,
        ST_HOLD
`ifdef PC_MISALIGN_HALT_EN
        ,
        ST_HALT
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_q, pend_d;        // redirect seen but PC not yet updated
    logic [31:0] tgt_q, tgt_d;          // latest redirect target
    logic        req_q, req_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
`ifdef PC_MISALIGN_HALT_EN
    logic        misalign_q, misalign_d;
`endif

    logic        redirect_eff;
    logic        pc_update;
    logic [31:0] pc_load;

    // A redirect arriving in the update cycle itself is used straight away (bypass).
    assign redirect_eff = pend_q | branch_taken_i;

    assign pc_select_o = redirect_eff;
    assign pc_branch_o = branch_taken_i ? branch_target_i : tgt_q;
    assign pc_add_o    = pc_q + PC_STEP;

`ifdef PC_MISALIGN_HALT_EN
    assign pc_load = pc_next_i;
`else
    logic unused_pc_next_lsb;
    assign unused_pc_next_lsb = ^pc_next_i[1:0];
    assign pc_load = {pc_next_i[31:2], 2'b00};
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        tgt_d      = tgt_q;
        req_d      = req_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        pc_update  = 1'b0;
`ifdef PC_MISALIGN_HALT_EN
        misalign_d = misalign_q;
`endif

        case (state_q)
            ST_BOOT: begin
                state_d = ST_REQ;
                req_d   = 1'b1;
            end
            ST_REQ: begin
                // Address is pc_q, which only moves on an update, so it is stable until grant
                // even if a redirect arrives meanwhile.
                if (imem_gnt_i) begin
                    state_d = ST_WAIT_RSP;
                    req_d   = 1'b0;
                end
            end
            ST_WAIT_RSP: begin
                if (imem_rvalid_i) begin
                    if (redirect_eff) begin
                        // Wrong-path word: drop it and go straight to the new target.
                        pc_update = 1'b1;
                    end else begin
                        instr_d    = imem_rdata_i;
                        instr_pc_d = pc_q;
                        valid_d    = 1'b1;
                        state_d    = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                // A redirect wins over acceptance: the held instruction is killed.
                if (!stall_i || redirect_eff) begin
                    pc_update = 1'b1;
                end
            end
`ifdef PC_MISALIGN_HALT_EN
            ST_HALT: begin
                // Terminal until reset.
            end
`endif
            default: begin
                state_d = ST_BOOT;
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase

        if (branch_taken_i) begin
            pend_d = 1'b1;
            tgt_d  = branch_target_i;
        end

        if (pc_update) begin
            pc_d    = pc_load;
            pend_d  = 1'b0;
            valid_d = 1'b0;
            state_d = ST_REQ;
            req_d   = 1'b1;
`ifdef PC_MISALIGN_HALT_EN
            if (pc_load[1:0] != 2'b00) begin
                state_d    = ST_HALT;
                req_d      = 1'b0;
                misalign_d = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VECTOR;
            pend_q     <= 1'b0;
            tgt_q      <= 32'h0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            instr_q    <= 32'h0;
            instr_pc_q <= 32'h0;
`ifdef PC_MISALIGN_HALT_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            tgt_q      <= tgt_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
`ifdef PC_MISALIGN_HALT_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign imem_req_o    = req_q;
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
`ifdef PC_MISALIGN_HALT_EN
    assign misalign_o    = misalign_q;
`endif

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Purpose     : self-checking bench for pc_fetch_controller (directed scenarios + randomized model run).
// Latency     : n/a
// Backpressure: bench drives stall_i randomly and in directed patterns.
module tb_pc_fetch_controller;

    logic        clk;
    logic        reset;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        stall_i;
    logic        pc_select_o;
    logic [31:0] pc_add_o;
    logic [31:0] pc_branch_o;
    logic [31:0] pc_next_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
`ifdef PC_MISALIGN_HALT_EN
    logic        misalign_o;
`endif

    int checks = 0;
    int errors = 0;

    pc_fetch_controller dut (
        .clk             (clk),
        .reset           (reset),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .stall_i         (stall_i),
        .pc_select_o     (pc_select_o),
        .pc_add_o        (pc_add_o),
        .pc_branch_o     (pc_branch_o),
        .pc_next_i       (pc_next_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_gnt_i      (imem_gnt_i),
        .imem_rvalid_i   (imem_rvalid_i),
        .imem_rdata_i    (imem_rdata_i),
        .instr_valid_o   (instr_valid_o),
        .instr_o         (instr_o),
        .instr_pc_o      (instr_pc_o)
`ifdef PC_MISALIGN_HALT_EN
        ,
        .misalign_o      (misalign_o)
`endif
    );

    // External next-PC mux, as it sits in the real datapath.
    assign pc_next_i = pc_select_o ? pc_branch_o : pc_add_o;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Memory harness: grants immediately, answers rsp_delay cycles after the grant.
    logic [31:0] q_req_addr[$];
    int          rsp_delay = 1;
    int          rsp_cnt   = 0;
    bit          rsp_pend  = 0;
    logic [31:0] rsp_addr  = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h10) return 32'h00A0_0093;
        return ~a ^ 32'h5A5A_0000;
    endfunction

    task automatic mem_cycle(input logic stl, input logic br, input logic [31:0] tgt);
        @(negedge clk);
        branch_taken_i  = br;
        branch_target_i = tgt;
        stall_i         = stl;
        imem_gnt_i      = imem_req_o;
        imem_rvalid_i   = 1'b0;
        if (rsp_pend) begin
            rsp_cnt = rsp_cnt - 1;
            if (rsp_cnt == 0) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = mem_word(rsp_addr);
                rsp_pend      = 0;
            end
        end
        if (imem_req_o) begin
            q_req_addr.push_back(imem_addr_o);
            rsp_pend = 1;
            rsp_cnt  = rsp_delay;
            rsp_addr = imem_addr_o;
        end
        #1;
    endtask

    task automatic run_to_grant(input logic [31:0] addr, input int budget, output bit found);
        found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            int n0 = q_req_addr.size();
            mem_cycle(1'b0, 1'b0, 32'h0);
            if (q_req_addr.size() > n0 && q_req_addr[$] == addr) found = 1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        branch_taken_i = 0; branch_target_i = 0; stall_i = 0;
        imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rsp_pend = 0;
        q_req_addr.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        branch_taken_i = 0; branch_target_i = 0; stall_i = 0;
        imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
        #1;
        checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b want 0", imem_req_o); end
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", instr_valid_o); end
        checks++; if (instr_o !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", instr_o); end
        checks++; if (instr_pc_o !== 32'h0) begin errors++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc_o); end
        checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", imem_addr_o); end
        checks++; if (pc_select_o !== 1'b0) begin errors++; $display("FAIL reset_sel: got %0b want 0", pc_select_o); end
        checks++; if (pc_add_o !== 32'h4) begin errors++; $display("FAIL reset_add: got %h want 4", pc_add_o); end
`ifdef PC_MISALIGN_HALT_EN
        checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %0b want 0", misalign_o); end
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rsp_pend = 0;
        q_req_addr.delete();
        #1;
        checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL boot_req: got %0b want 0", imem_req_o); end
        mem_cycle(1'b0, 1'b0, 32'h0);
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin errors++; $display("FAIL first_req: got req=%0b addr=%h want req=1 addr=0", imem_req_o, imem_addr_o); end
    endtask

    task automatic test_sequential();
        int          gcyc[$];
        logic [31:0] apc[$];
        logic [31:0] adat[$];
        bit          sel_seen = 0;
        do_reset();
        rsp_delay = 1;
        for (int c = 1; c <= 10; c++) begin
            int n0 = q_req_addr.size();
            mem_cycle(1'b0, 1'b0, 32'h0);
            if (q_req_addr.size() > n0) gcyc.push_back(c);
            if (instr_valid_o) begin apc.push_back(instr_pc_o); adat.push_back(instr_o); end
            if (pc_select_o) sel_seen = 1;
        end
        checks++;
        if (q_req_addr.size() < 3 || apc.size() < 3 || gcyc.size() < 2) begin
            errors++; $display("FAIL seq_counts: got reqs=%0d accepts=%0d want >=3 each", q_req_addr.size(), apc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                logic [31:0] exp_a;
                exp_a = 32'(i * 4);
                checks++; if (q_req_addr[i] !== exp_a) begin errors++; $display("FAIL seq_addr%0d: got %h want %h", i, q_req_addr[i], exp_a); end
                checks++; if (apc[i] !== exp_a) begin errors++; $display("FAIL seq_instr_pc%0d: got %h want %h", i, apc[i], exp_a); end
                checks++; if (adat[i] !== mem_word(exp_a)) begin errors++; $display("FAIL seq_instr%0d: got %h want %h", i, adat[i], mem_word(exp_a)); end
            end
            checks++; if (gcyc[1] - gcyc[0] != 3) begin errors++; $display("FAIL seq_spacing: got %0d want 3", gcyc[1] - gcyc[0]); end
        end
        checks++; if (sel_seen !== 1'b0) begin errors++; $display("FAIL seq_select: got 1 want 0"); end
    endtask

    task automatic test_stall();
        bit found;
        do_reset();
        rsp_delay = 1;
        run_to_grant(32'h10, 40, found);
        checks++; if (!found) begin errors++; $display("FAIL stall_reach: got no fetch at 10 want fetch"); end
        mem_cycle(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            mem_cycle(1'b1, 1'b0, 32'h0);
            checks++;
            if (instr_valid_o !== 1'b1 || instr_o !== 32'h00A0_0093 || instr_pc_o !== 32'h10 || imem_req_o !== 1'b0) begin
                errors++; $display("FAIL stall_hold%0d: got v=%0b i=%h pc=%h req=%0b want v=1 i=00a00093 pc=10 req=0", i, instr_valid_o, instr_o, instr_pc_o, imem_req_o);
            end
        end
        mem_cycle(1'b0, 1'b0, 32'h0);
        checks++; if (instr_valid_o !== 1'b1 || imem_req_o !== 1'b0) begin errors++; $display("FAIL stall_accept: got v=%0b req=%0b want v=1 req=0", instr_valid_o, imem_req_o); end
        mem_cycle(1'b0, 1'b0, 32'h0);
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h14) begin errors++; $display("FAIL stall_next: got req=%0b addr=%h want req=1 addr=14", imem_req_o, imem_addr_o); end
    endtask

    task automatic test_branch_wait();
        bit found;
        do_reset();
        rsp_delay = 2;
        run_to_grant(32'h20, 80, found);
        checks++; if (!found) begin errors++; $display("FAIL bw_reach: got no fetch at 20 want fetch"); end
        mem_cycle(1'b0, 1'b1, 32'h100);
        checks++; if (pc_select_o !== 1'b1 || pc_branch_o !== 32'h100) begin errors++; $display("FAIL bw_sel: got sel=%0b br=%h want sel=1 br=100", pc_select_o, pc_branch_o); end
        mem_cycle(1'b0, 1'b0, 32'h0);
        checks++; if (instr_valid_o !== 1'b0 || pc_select_o !== 1'b1 || pc_branch_o !== 32'h100) begin errors++; $display("FAIL bw_drop: got v=%0b sel=%0b br=%h want v=0 sel=1 br=100", instr_valid_o, pc_select_o, pc_branch_o); end
        mem_cycle(1'b0, 1'b0, 32'h0);
        checks++; if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin errors++; $display("FAIL bw_next: got v=%0b req=%0b addr=%h want v=0 req=1 addr=100", instr_valid_o, imem_req_o, imem_addr_o); end
    endtask

    task automatic test_two_branches();
        bit found;
        do_reset();
        rsp_delay = 3;
        run_to_grant(32'h8, 60, found);
        checks++; if (!found) begin errors++; $display("FAIL tb_reach: got no fetch at 8 want fetch"); end
        mem_cycle(1'b0, 1'b1, 32'h200);
        mem_cycle(1'b0, 1'b1, 32'h300);
        mem_cycle(1'b0, 1'b0, 32'h0);
        checks++; if (pc_branch_o !== 32'h300 || pc_select_o !== 1'b1 || instr_valid_o !== 1'b0) begin errors++; $display("FAIL tb_latest: got br=%h sel=%0b v=%0b want br=300 sel=1 v=0", pc_branch_o, pc_select_o, instr_valid_o); end
        mem_cycle(1'b0, 1'b0, 32'h0);
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h300) begin errors++; $display("FAIL tb_next: got req=%0b addr=%h want req=1 addr=300", imem_req_o, imem_addr_o); end
    endtask

    task automatic test_hold_branch();
        bit found;
        do_reset();
        rsp_delay = 1;
        run_to_grant(32'h4, 30, found);
        checks++; if (!found) begin errors++; $display("FAIL hb_reach: got no fetch at 4 want fetch"); end
        mem_cycle(1'b0, 1'b0, 32'h0);
        mem_cycle(1'b0, 1'b1, 32'h40);
        checks++; if (instr_valid_o !== 1'b1 || pc_select_o !== 1'b1 || pc_branch_o !== 32'h40) begin errors++; $display("FAIL hb_sel: got v=%0b sel=%0b br=%h want v=1 sel=1 br=40", instr_valid_o, pc_select_o, pc_branch_o); end
        mem_cycle(1'b0, 1'b0, 32'h0);
        checks++; if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h40) begin errors++; $display("FAIL hb_next: got v=%0b req=%0b addr=%h want v=0 req=1 addr=40", instr_valid_o, imem_req_o, imem_addr_o); end
    endtask

    task automatic test_wrap();
        bit found;
        do_reset();
        rsp_delay = 1;
        run_to_grant(32'h0, 10, found);
        checks++; if (!found) begin errors++; $display("FAIL wrap_reach: got no fetch at 0 want fetch"); end
        mem_cycle(1'b0, 1'b0, 32'h0);
        mem_cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
        mem_cycle(1'b0, 1'b0, 32'h0);
        checks++; if (imem_addr_o !== 32'hFFFF_FFFC || pc_add_o !== 32'h0) begin errors++; $display("FAIL wrap_add: got addr=%h add=%h want addr=fffffffc add=0", imem_addr_o, pc_add_o); end
        mem_cycle(1'b0, 1'b0, 32'h0);
        mem_cycle(1'b0, 1'b0, 32'h0);
        checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_instr: got v=%0b pc=%h want v=1 pc=fffffffc", instr_valid_o, instr_pc_o); end
        mem_cycle(1'b0, 1'b0, 32'h0);
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin errors++; $display("FAIL wrap_next: got req=%0b addr=%h want req=1 addr=0", imem_req_o, imem_addr_o); end
    endtask

    task automatic test_reset_midfetch();
        bit found;
        do_reset();
        rsp_delay = 4;
        run_to_grant(32'h4, 30, found);
        checks++; if (!found) begin errors++; $display("FAIL rm_reach: got no fetch at 4 want fetch"); end
        mem_cycle(1'b0, 1'b0, 32'h0);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0 || instr_o !== 32'h0 || instr_pc_o !== 32'h0 || imem_addr_o !== 32'h0 || pc_select_o !== 1'b0) begin
            errors++; $display("FAIL rm_async: got req=%0b v=%0b i=%h pc=%h addr=%h sel=%0b want all zero", imem_req_o, instr_valid_o, instr_o, instr_pc_o, imem_addr_o, pc_select_o);
        end
        @(negedge clk);
        reset = 1'b0;
        rsp_pend = 0;
        rsp_delay = 1;
        imem_gnt_i = 0; imem_rvalid_i = 0;
        mem_cycle(1'b0, 1'b0, 32'h0);
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin errors++; $display("FAIL rm_refetch: got req=%0b addr=%h want req=1 addr=0", imem_req_o, imem_addr_o); end
        mem_cycle(1'b1, 1'b0, 32'h0);
        mem_cycle(1'b1, 1'b0, 32'h0);
        checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h0 || instr_o !== mem_word(32'h0)) begin errors++; $display("FAIL rm_instr: got v=%0b pc=%h i=%h want v=1 pc=0 i=%h", instr_valid_o, instr_pc_o, instr_o, mem_word(32'h0)); end
    endtask

    task automatic test_misalign();
        bit found;
        do_reset();
        rsp_delay = 1;
        run_to_grant(32'h4, 30, found);
        checks++; if (!found) begin errors++; $display("FAIL ma_reach: got no fetch at 4 want fetch"); end
        mem_cycle(1'b0, 1'b0, 32'h0);
        mem_cycle(1'b0, 1'b1, 32'h102);
`ifdef PC_MISALIGN_HALT_EN
        begin
            int reqs = 0;
            int vals = 0;
            for (int i = 0; i < 8; i++) begin
                mem_cycle(1'b0, 1'b0, 32'h0);
                if (imem_req_o) reqs++;
                if (instr_valid_o) vals++;
            end
            checks++; if (misalign_o !== 1'b1) begin errors++; $display("FAIL ma_flag: got %0b want 1", misalign_o); end
            checks++; if (reqs != 0 || vals != 0) begin errors++; $display("FAIL ma_halt: got reqs=%0d valids=%0d want 0", reqs, vals); end
        end
`else
        mem_cycle(1'b0, 1'b0, 32'h0);
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin errors++; $display("FAIL ma_mask: got req=%0b addr=%h want req=1 addr=100", imem_req_o, imem_addr_o); end
`endif
    endtask

    // Randomized run against a transaction-level model of the fetch rules.
    task automatic test_random();
        logic [31:0] m_pc = 32'h0;
        logic [31:0] m_tgt = 32'h0;
        logic [31:0] m_hdat = 32'h0;
        logic [31:0] m_hpc = 32'h0;
        bit m_pend = 0, m_req = 1, m_out = 0, m_hold = 0;
        int n_acc = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic br, stl, gnt, rv, eff, upd;
            logic [31:0] tgt, rdat;
            @(negedge clk);
            br   = ($urandom_range(0, 5) == 0);
            tgt  = $urandom & 32'h0000_FFFC;
`ifndef PC_MISALIGN_HALT_EN
            if ($urandom_range(0, 3) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
`endif
            stl  = ($urandom_range(0, 2) == 0);
            gnt  = $urandom_range(0, 1) == 1;
            rv   = m_out && ($urandom_range(0, 1) == 1);
            rdat = $urandom;
            branch_taken_i = br; branch_target_i = tgt; stall_i = stl;
            imem_gnt_i = gnt; imem_rvalid_i = rv; imem_rdata_i = rdat;
            #1;
            checks++; if (imem_req_o !== m_req) begin errors++; $display("FAIL rnd_req c%0d: got %0b want %0b", c, imem_req_o, m_req); end
            checks++; if (imem_addr_o !== m_pc) begin errors++; $display("FAIL rnd_addr c%0d: got %h want %h", c, imem_addr_o, m_pc); end
            checks++; if (instr_valid_o !== m_hold) begin errors++; $display("FAIL rnd_valid c%0d: got %0b want %0b", c, instr_valid_o, m_hold); end
            if (m_hold) begin
                checks++; if (instr_o !== m_hdat || instr_pc_o !== m_hpc) begin errors++; $display("FAIL rnd_instr c%0d: got %h@%h want %h@%h", c, instr_o, instr_pc_o, m_hdat, m_hpc); end
            end
            checks++; if (pc_select_o !== (m_pend || br)) begin errors++; $display("FAIL rnd_sel c%0d: got %0b want %0b", c, pc_select_o, m_pend || br); end
            checks++; if (pc_branch_o !== (br ? tgt : m_tgt)) begin errors++; $display("FAIL rnd_br c%0d: got %h want %h", c, pc_branch_o, br ? tgt : m_tgt); end
            checks++; if (pc_add_o !== m_pc + 32'd4) begin errors++; $display("FAIL rnd_add c%0d: got %h want %h", c, pc_add_o, m_pc + 32'd4); end

            eff = m_pend || br;
            upd = 0;
            if (m_req) begin
                if (gnt) begin m_req = 0; m_out = 1; end
            end else if (m_out) begin
                if (rv) begin
                    m_out = 0;
                    if (eff) upd = 1;
                    else begin m_hold = 1; m_hdat = rdat; m_hpc = m_pc; end
                end
            end else if (m_hold) begin
                if (eff || !stl) begin
                    upd = 1;
                    if (!eff) n_acc++;
                end
            end
            if (br) begin m_pend = 1; m_tgt = tgt; end
            if (upd) begin
                m_pc = eff ? m_tgt : m_pc + 32'd4;
                m_pc[1:0] = 2'b00;
                m_pend = 0; m_req = 1; m_hold = 0;
            end
        end
        checks++; if (n_acc < 50) begin errors++; $display("FAIL rnd_progress: got %0d accepts want >=50", n_acc); end
    endtask

    initial begin
        reset = 1'b1;
        branch_taken_i = 0; branch_target_i = 0; stall_i = 0;
        imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
        test_reset();
        test_sequential();
        test_stall();
        test_branch_wait();
        test_two_branches();
        test_hold_branch();
        test_wrap();
        test_reset_midfetch();
        test_misalign();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
